// File: rtl/alu_share_arb.sv
// Round-robin arbiter time-sharing one combinational ALU between two requesters,
// with a one-entry registered response buffer per requester.
module alu_share_arb #(
  parameter bit PRIO_RESET = 1'b0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [31:0]      r0_a,
  input  logic [31:0]      r0_b,
  input  logic [4:0]       r0_shamt,
  input  logic [2:0]       r0_ctl,
  output logic             r0_rvalid,
  input  logic             r0_rready,
  output logic [31:0]      r0_result,
  output logic             r0_zero,
  output logic             r0_notzero,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [31:0]      r1_a,
  input  logic [31:0]      r1_b,
  input  logic [4:0]       r1_shamt,
  input  logic [2:0]       r1_ctl,
  output logic             r1_rvalid,
  input  logic             r1_rready,
  output logic [31:0]      r1_result,
  output logic             r1_zero,
  output logic             r1_notzero,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [4:0]       alu_shamt,
  output logic [2:0]       alu_control,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  input  logic             alu_notzero,
  output logic [1:0]       grant,
  output logic [CNT_W-1:0] ops_count
);

  logic last;
  logic elig0, elig1;
  logic grant0, grant1;

  // A requester whose response buffer is full and not draining cannot be granted.
  always_comb begin
    elig0  = r0_valid && (!r0_rvalid || r0_rready);
    elig1  = r1_valid && (!r1_rvalid || r1_rready);
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (reset_n) begin
      if (elig0 && elig1) begin
        grant0 = last;
        grant1 = !last;
      end else begin
        grant0 = elig0;
        grant1 = elig1;
      end
    end
  end

  assign r0_ready = grant0;
  assign r1_ready = grant1;
  assign grant    = {grant1, grant0};

  // Idle drive is an add of zeros so the shared ALU never sees X.
  always_comb begin
    alu_a       = 32'h0;
    alu_b       = 32'h0;
    alu_shamt   = 5'h0;
    alu_control = 3'b010;
    if (grant0) begin
      alu_a       = r0_a;
      alu_b       = r0_b;
      alu_shamt   = r0_shamt;
      alu_control = r0_ctl;
    end else if (grant1) begin
      alu_a       = r1_a;
      alu_b       = r1_b;
      alu_shamt   = r1_shamt;
      alu_control = r1_ctl;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last      <= !PRIO_RESET;
      ops_count <= '0;
    end else if (grant0 || grant1) begin
      last      <= grant1;
      ops_count <= ops_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // A same-cycle accept overwrites a draining buffer and keeps rvalid high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r0_rvalid  <= 1'b0;
      r0_result  <= 32'h0;
      r0_zero    <= 1'b0;
      r0_notzero <= 1'b0;
    end else if (grant0) begin
      r0_rvalid  <= 1'b1;
      r0_result  <= alu_result;
      r0_zero    <= alu_zero;
      r0_notzero <= alu_notzero;
    end else if (r0_rready) begin
      r0_rvalid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r1_rvalid  <= 1'b0;
      r1_result  <= 32'h0;
      r1_zero    <= 1'b0;
      r1_notzero <= 1'b0;
    end else if (grant1) begin
      r1_rvalid  <= 1'b1;
      r1_result  <= alu_result;
      r1_zero    <= alu_zero;
      r1_notzero <= alu_notzero;
    end else if (r1_rready) begin
      r1_rvalid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: a behavioural ALU sits on the shared port and
// a per-requester scoreboard queue checks every consumed response.
module tb_alu_share_arb;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        notzero;
  } resp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        r0_valid, r0_rready, r1_valid, r1_rready;
  logic [31:0] r0_a, r0_b, r1_a, r1_b;
  logic [4:0]  r0_shamt, r1_shamt;
  logic [2:0]  r0_ctl, r1_ctl;
  logic        r0_ready, r1_ready, r0_rvalid, r1_rvalid;
  logic [31:0] r0_result, r1_result;
  logic        r0_zero, r0_notzero, r1_zero, r1_notzero;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [4:0]  alu_shamt;
  logic [2:0]  alu_control;
  logic        alu_zero, alu_notzero;
  logic [1:0]  grant;
  logic [15:0] ops_count;

  logic        w_r0_ready, w_r1_ready, w_r0_rvalid, w_r1_rvalid;
  logic [31:0] w_r0_result, w_r1_result, w_alu_a, w_alu_b;
  logic        w_r0_zero, w_r0_notzero, w_r1_zero, w_r1_notzero;
  logic [4:0]  w_alu_shamt;
  logic [2:0]  w_alu_control;
  logic [1:0]  w_grant;
  logic [3:0]  w_ops_count;

  int total = 0;
  int bad   = 0;
  resp_t exp0_q[$];
  resp_t exp1_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [4:0] sh, input logic [2:0] c);
    case (c)
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b111:  return (a < b) ? 32'd1 : 32'd0;
      3'b011:  return a << sh;
      default: return 32'h0;
    endcase
  endfunction

  always_comb begin
    alu_result  = alu_fn(alu_a, alu_b, alu_shamt, alu_control);
    alu_zero    = (alu_result == 32'h0);
    alu_notzero = (alu_result != 32'h0);
  end

  alu_share_arb #(.PRIO_RESET(1'b0), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b),
    .r0_shamt(r0_shamt), .r0_ctl(r0_ctl), .r0_rvalid(r0_rvalid), .r0_rready(r0_rready),
    .r0_result(r0_result), .r0_zero(r0_zero), .r0_notzero(r0_notzero),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b),
    .r1_shamt(r1_shamt), .r1_ctl(r1_ctl), .r1_rvalid(r1_rvalid), .r1_rready(r1_rready),
    .r1_result(r1_result), .r1_zero(r1_zero), .r1_notzero(r1_notzero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_notzero(alu_notzero),
    .grant(grant), .ops_count(ops_count)
  );

  // Narrow-counter copy sees the same requests, used only for the wrap check.
  alu_share_arb #(.PRIO_RESET(1'b0), .CNT_W(4)) dut_w (
    .clk(clk), .reset_n(reset_n),
    .r0_valid(r0_valid), .r0_ready(w_r0_ready), .r0_a(r0_a), .r0_b(r0_b),
    .r0_shamt(r0_shamt), .r0_ctl(r0_ctl), .r0_rvalid(w_r0_rvalid), .r0_rready(r0_rready),
    .r0_result(w_r0_result), .r0_zero(w_r0_zero), .r0_notzero(w_r0_notzero),
    .r1_valid(r1_valid), .r1_ready(w_r1_ready), .r1_a(r1_a), .r1_b(r1_b),
    .r1_shamt(r1_shamt), .r1_ctl(r1_ctl), .r1_rvalid(w_r1_rvalid), .r1_rready(r1_rready),
    .r1_result(w_r1_result), .r1_zero(w_r1_zero), .r1_notzero(w_r1_notzero),
    .alu_a(w_alu_a), .alu_b(w_alu_b), .alu_shamt(w_alu_shamt), .alu_control(w_alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_notzero(alu_notzero),
    .grant(w_grant), .ops_count(w_ops_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check grant and ALU drive, consume responses, push new expectations.
  task automatic applyStimulus(input logic [1:0] exp_grant, input string tag);
    resp_t e;
    #1;
    checkOutput({tag, "_grant"}, 32'(grant), 32'(exp_grant));
    checkOutput({tag, "_ready"}, 32'({r1_ready, r0_ready}), 32'(exp_grant));
    if (r0_rvalid && r0_rready) begin
      if (exp0_q.size() == 0) checkOutput({tag, "_r0_q_empty"}, 32'(exp0_q.size()), 32'd1);
      else begin
        e = exp0_q.pop_front();
        checkOutput({tag, "_r0_result"}, r0_result, e.result);
        checkOutput({tag, "_r0_zero"}, 32'(r0_zero), 32'(e.zero));
        checkOutput({tag, "_r0_notzero"}, 32'(r0_notzero), 32'(e.notzero));
      end
    end
    if (r1_rvalid && r1_rready) begin
      if (exp1_q.size() == 0) checkOutput({tag, "_r1_q_empty"}, 32'(exp1_q.size()), 32'd1);
      else begin
        e = exp1_q.pop_front();
        checkOutput({tag, "_r1_result"}, r1_result, e.result);
        checkOutput({tag, "_r1_zero"}, 32'(r1_zero), 32'(e.zero));
        checkOutput({tag, "_r1_notzero"}, 32'(r1_notzero), 32'(e.notzero));
      end
    end
    if (exp_grant == 2'b01) begin
      checkOutput({tag, "_alu_a"}, alu_a, r0_a);
      checkOutput({tag, "_alu_b"}, alu_b, r0_b);
      checkOutput({tag, "_alu_ctl"}, 32'(alu_control), 32'(r0_ctl));
      e.result  = alu_fn(r0_a, r0_b, r0_shamt, r0_ctl);
      e.zero    = (e.result == 32'h0);
      e.notzero = (e.result != 32'h0);
      exp0_q.push_back(e);
    end else if (exp_grant == 2'b10) begin
      checkOutput({tag, "_alu_a"}, alu_a, r1_a);
      checkOutput({tag, "_alu_shamt"}, 32'(alu_shamt), 32'(r1_shamt));
      checkOutput({tag, "_alu_ctl"}, 32'(alu_control), 32'(r1_ctl));
      e.result  = alu_fn(r1_a, r1_b, r1_shamt, r1_ctl);
      e.zero    = (e.result == 32'h0);
      e.notzero = (e.result != 32'h0);
      exp1_q.push_back(e);
    end else begin
      checkOutput({tag, "_alu_idle_a"}, alu_a, 32'h0);
      checkOutput({tag, "_alu_idle_ctl"}, 32'(alu_control), 32'h2);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp0_q.delete();
    exp1_q.delete();
  endtask

  initial begin
    reset_n = 1'b0;
    r0_rready = 1'b1; r1_rready = 1'b1;
    r0_valid = 1'b1;  r0_a = 32'd7; r0_b = 32'd7; r0_shamt = 5'd0;  r0_ctl = 3'b110;
    r1_valid = 1'b1;  r1_a = 32'd1; r1_b = 32'd0; r1_shamt = 5'd31; r1_ctl = 3'b011;

    $display("[TB] reset hold with both requests valid");
    applyStimulus(2'b00, "reset_hold");
    checkOutput("reset_r0_rvalid", 32'(r0_rvalid), 32'd0);
    checkOutput("reset_r1_rvalid", 32'(r1_rvalid), 32'd0);
    checkOutput("reset_ops", 32'(ops_count), 32'd0);
    checkOutput("reset_r0_result", r0_result, 32'd0);

    $display("[TB] contention");
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) applyStimulus((i % 2 == 0) ? 2'b01 : 2'b10, "contention");
    checkOutput("contention_ops", 32'(ops_count), 32'd6);
    r0_valid = 1'b0; r1_valid = 1'b0;
    applyStimulus(2'b00, "contention_drain");

    $display("[TB] single op");
    doReset();
    r0_rready = 1'b0;
    r0_valid = 1'b1; r0_a = 32'd5; r0_b = 32'd3; r0_shamt = 5'd0; r0_ctl = 3'b010;
    applyStimulus(2'b01, "single");
    r0_valid = 1'b0;
    checkOutput("single_rvalid", 32'(r0_rvalid), 32'd1);
    checkOutput("single_result", r0_result, 32'd8);
    checkOutput("single_zero", 32'(r0_zero), 32'd0);
    checkOutput("single_notzero", 32'(r0_notzero), 32'd1);
    checkOutput("single_ops", 32'(ops_count), 32'd1);

    $display("[TB] backpressure");
    r0_valid = 1'b1; r0_a = 32'd10; r0_b = 32'd20; r0_ctl = 3'b010;
    r1_valid = 1'b1; r1_a = 32'hFF; r1_b = 32'h0F; r1_shamt = 5'd0; r1_ctl = 3'b000;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b10, "bp_hold");
      checkOutput("bp_hold_r0_result", r0_result, 32'd8);
      checkOutput("bp_hold_r0_rvalid", 32'(r0_rvalid), 32'd1);
    end
    r0_rready = 1'b1;
    applyStimulus(2'b01, "bp_release");
    checkOutput("bp_release_rvalid", 32'(r0_rvalid), 32'd1);
    checkOutput("bp_release_result", r0_result, 32'd30);
    r0_valid = 1'b0; r1_valid = 1'b0;
    applyStimulus(2'b00, "bp_drain");
    checkOutput("bp_drain_r0_rvalid", 32'(r0_rvalid), 32'd0);

    $display("[TB] slt and or");
    r1_valid = 1'b1; r1_a = 32'hFFFFFFFF; r1_b = 32'd1; r1_ctl = 3'b111;
    applyStimulus(2'b10, "slt");
    checkOutput("slt_result", r1_result, 32'd0);
    checkOutput("slt_zero", 32'(r1_zero), 32'd1);
    r1_a = 32'hF0; r1_b = 32'h0F; r1_ctl = 3'b001;
    applyStimulus(2'b10, "or");
    checkOutput("or_result", r1_result, 32'hFF);
    checkOutput("or_zero", 32'(r1_zero), 32'd0);
    r1_valid = 1'b0;
    applyStimulus(2'b00, "or_drain");

    $display("[TB] reset during accept");
    r0_valid = 1'b1; r0_a = 32'd1; r0_b = 32'd1; r0_ctl = 3'b010;
    #1;
    checkOutput("midrst_grant_before", 32'(grant), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_grant_in_reset", 32'(grant), 32'h0);
    checkOutput("midrst_alu_a_in_reset", alu_a, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    r0_valid = 1'b0;
    exp0_q.delete();
    exp1_q.delete();
    checkOutput("midrst_r0_rvalid", 32'(r0_rvalid), 32'd0);
    checkOutput("midrst_r1_rvalid", 32'(r1_rvalid), 32'd0);
    checkOutput("midrst_ops", 32'(ops_count), 32'd0);
    checkOutput("midrst_r1_result", r1_result, 32'd0);
    applyStimulus(2'b00, "midrst_after");
    checkOutput("midrst_r0_rvalid_after", 32'(r0_rvalid), 32'd0);

    $display("[TB] counter wrap");
    r0_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      r0_a = 32'(i); r0_b = 32'h100; r0_ctl = 3'b010;
      applyStimulus(2'b01, "wrap");
    end
    r0_valid = 1'b0;
    applyStimulus(2'b00, "wrap_drain");
    checkOutput("wrap_ops16", 32'(ops_count), 32'd17);
    checkOutput("wrap_ops4", 32'(w_ops_count), 32'd1);

    checkOutput("final_q0_empty", 32'(exp0_q.size()), 32'd0);
    checkOutput("final_q1_empty", 32'(exp1_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
